mult_div_unit: RTL and testbench

//  Iterative multi-cycle multiply/divide engine behind the single-cycle ALU in EX.

---
 rtl/mdu_pkg.sv | 8 +
 rtl/mult_div_unit.sv | 124 ++++++++++++
 tb/tb_mult_div_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: ALU op codes, FSM state type and counter sizing shared by the multiply/divide unit and ALU decode
package mdu_pkg;
    localparam logic [3:0] ALU_MULT = 4'd12;
    localparam logic [3:0] ALU_DIV  = 4'd13;
    localparam int MDU_XLEN  = 32;
    localparam int MDU_CNT_W = $clog2(MDU_XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply / restoring divide engine with start/busy/done handshake
//   clk, rst (sync, active-high)
//   start, alu_operation[3:0], input1/input2[XLEN-1:0] : request and operands, sampled in IDLE/DONE only
//   busy : iterating; done : one-cycle completion pulse
//   hi/lo[XLEN-1:0] : product halves or remainder/quotient; div_by_zero : last DIV had zero divisor
//   Define MDU_SIGNED_EN for two's-complement operands (magnitude datapath, sign fix on entry to DONE).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_operation,
    input  logic [XLEN-1:0] input1,
    input  logic [XLEN-1:0] input2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);
    localparam int CW = $clog2(XLEN);
    mdu_state_t r_state, w_next;
    logic [2*XLEN-1:0] r_acc, w_acc_next, w_mul_next, w_div_next, w_res;
    logic [XLEN-1:0]   r_opnd, r_hi, r_lo, w_a_mag, w_b_mag;
    logic [CW-1:0]     r_count;
    logic              r_dz;
    logic [XLEN:0]     w_sum, w_rem_sh, w_diff;
    logic              w_idle_start, w_is_mul, w_is_div, w_b_zero, w_last, w_ge;
`ifdef MDU_SIGNED_EN
    logic              r_neg_q, r_neg_r;
`endif
    assign busy        = (r_state == MUL) || (r_state == DIV);
    assign done        = (r_state == DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dz;
    always_comb begin
        w_idle_start = start && ((r_state == IDLE) || (r_state == DONE));
        w_is_mul     = alu_operation == ALU_MULT;
        w_is_div     = alu_operation == ALU_DIV;
        w_b_zero     = input2 == '0;
        w_last       = r_count == CW'(XLEN - 1);
        w_next       = busy ? (w_last ? DONE : r_state)
                     : !start ? IDLE
                     : w_is_mul ? MUL
                     : w_is_div ? (w_b_zero ? DONE : DIV)
                     : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
`ifdef MDU_SIGNED_EN
        w_a_mag = input1[XLEN-1] ? -input1 : input1;
        w_b_mag = input2[XLEN-1] ? -input2 : input2;
`else
        w_a_mag = input1;
        w_b_mag = input2;
`endif
        // Multiply: add multiplicand into the upper half when the current multiplier bit is set, then shift right.
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_next = {w_sum, r_acc[XLEN-1:1]};
        // Divide: shift the next dividend bit into the remainder; the borrow bit of the trial subtract decides the quotient bit.
        w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
        w_diff     = w_rem_sh - {1'b0, r_opnd};
        w_ge       = !w_diff[XLEN];
        w_div_next = {w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
        w_acc_next = (r_state == MUL) ? w_mul_next : w_div_next;
`ifdef MDU_SIGNED_EN
        w_res = (r_state == MUL) ? (r_neg_q ? -w_acc_next : w_acc_next)
              : {r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN],
                 r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0]};
`else
        w_res = w_acc_next;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_opnd  <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz    <= 1'b0;
        end else if (w_idle_start && w_is_mul) begin
            r_acc   <= {{XLEN{1'b0}}, w_b_mag};
            r_opnd  <= w_a_mag;
            r_count <= '0;
        end else if (w_idle_start && w_is_div && w_b_zero) begin
            r_hi <= input1;
            r_lo <= '1;
            r_dz <= 1'b1;
        end else if (w_idle_start && w_is_div) begin
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
            r_opnd  <= w_b_mag;
            r_count <= '0;
        end else if (busy) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_hi <= w_res[2*XLEN-1:XLEN];
                r_lo <= w_res[XLEN-1:0];
                r_dz <= 1'b0;
            end
        end
    end
`ifdef MDU_SIGNED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_idle_start) begin
            r_neg_q <= input1[XLEN-1] ^ input2[XLEN-1];
            r_neg_r <= input1[XLEN-1];
        end
    end
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
    import mdu_pkg::*;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  op;
    logic [31:0] in1, in2;
    logic        busy, done, dz;
    logic [31:0] hi, lo;
    logic [31:0] m_hi, m_lo;
    logic        m_dz;
    int          checks = 0;
    int          errors = 0;
    mult_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_operation(op),
        .input1(in1), .input2(in2), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(dz)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Reference: plain integer arithmetic on the operands; returns the expected busy-cycle count.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
`ifdef MDU_SIGNED_EN
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        logic [63:0] p;
`endif
        lat = 32;
        if (o == ALU_MULT) begin
`ifdef MDU_SIGNED_EN
            p = sa * sb;
`else
            p = {32'd0, a} * {32'd0, b};
`endif
            m_hi = p[63:32];
            m_lo = p[31:0];
            m_dz = 1'b0;
        end else if (b == 32'd0) begin
            lat  = 0;
            m_hi = a;
            m_lo = 32'hFFFF_FFFF;
            m_dz = 1'b1;
        end else begin
`ifdef MDU_SIGNED_EN
            q = sa / sb;
            r = sa % sb;
            m_hi = r[31:0];
            m_lo = q[31:0];
`else
            m_hi = a % b;
            m_lo = a / b;
`endif
            m_dz = 1'b0;
        end
    endtask
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit b2b, input bit stay, input int poke, input string tag);
        int lat, n;
        if (!b2b) @(negedge clk);
        op = o; in1 = a; in2 = b; start = 1'b1;
        model(o, a, b, lat);
        @(posedge clk); #1;
        start = 1'b0; in1 = $urandom; in2 = $urandom;
        chk({tag, " done_after_start"}, done, lat == 0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            start = (n == poke);
            if (n == poke) begin op = ALU_DIV; in2 = 32'd0; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, n, lat);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " busy_in_done"}, busy, 1'b0);
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
        chk({tag, " div_by_zero"}, dz, m_dz);
        if (!stay) begin
            @(posedge clk); #1;
            chk({tag, " done_drops"}, done, 1'b0);
            chk({tag, " idle_busy"}, busy, 1'b0);
        end
    endtask
    task automatic ignored_op(input logic [3:0] o, input string tag);
        @(negedge clk);
        op = o; in1 = $urandom; in2 = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " hi_hold"}, hi, m_hi);
        chk({tag, " lo_hold"}, lo, m_lo);
        chk({tag, " dz_hold"}, dz, m_dz);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
    initial begin
        bit saw;
        logic [3:0] o;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; op = 4'd0; in1 = '0; in2 = '0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset dz", dz, 1'b0);
        rst = 1'b0;
        do_op(ALU_MULT, 32'd7, 32'd6, 0, 0, 0, "mul7x6");
        chk("mul7x6 lo literal", lo, 32'd42);
        do_op(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "mul_ones");
        do_op(ALU_DIV, 32'd100, 32'd7, 0, 0, 0, "div100_7");
        chk("div100_7 lo literal", lo, 32'd14);
        chk("div100_7 hi literal", hi, 32'd2);
        do_op(ALU_DIV, 32'd5, 32'd0, 0, 0, 0, "div5_0");
        ignored_op(4'd8, "add_ignored");
        do_op(ALU_MULT, -32'sd3, 32'd5, 0, 0, 0, "mul_m3x5");
        do_op(ALU_DIV, -32'sd7, 32'd2, 0, 0, 0, "div_m7_2");
        do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_min_m1");
        do_op(ALU_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 5, "start_while_busy");
        do_op(ALU_DIV, 32'd100, 32'd7, 0, 1, 0, "b2b_first");
        do_op(ALU_MULT, $urandom, $urandom, 1, 1, 0, "b2b_second");
        do_op(ALU_DIV, 32'd5, 32'd0, 1, 1, 0, "b2b_dz");
        do_op(ALU_DIV, $urandom, $urandom_range(1, 1000), 1, 0, 0, "b2b_after_dz");
        for (int i = 0; i < 12; i++) begin
            o = i[0] ? ALU_DIV : ALU_MULT;
            a = $urandom;
            b = (i % 5 == 3) ? 32'd0 : (i % 3 == 0) ? $urandom_range(1, 300) : $urandom;
            do_op(o, a, b, 0, 0, 0, "random");
        end
        do_op(ALU_MULT, 32'hDEAD_BEEF, 32'h0000_0F0F, 0, 0, 0, "pre_reset");
        @(negedge clk);
        op = ALU_MULT; in1 = 32'hCAFE_F00D; in2 = 32'h1357_9BDF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort dz", dz, 1'b0);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        chk("abort no_done_follows", saw, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
